// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg
//   Shared definitions for the clock-pair frequency scheduler:
//   - state_t      : sweep FSM states
//   - CODE_*       : result codes reported on res_code
//   - pair_p/pair_q: fixed pair-index -> (P,Q) monitored-clock mapping
package clk_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SELECT  = 3'd1,
      ST_ARM     = 3'd2,
      ST_MEASURE = 3'd3,
      ST_COMPARE = 3'd4,
      ST_REPORT  = 3'd5
   } state_t;

   localparam logic [1:0] CODE_EQ  = 2'b00;
   localparam logic [1:0] CODE_LT  = 2'b01;
   localparam logic [1:0] CODE_GT  = 2'b10;
   localparam logic [1:0] CODE_TMO = 2'b11;

   localparam int NPAIR = 6;

   // Pair table: 0=(0,1) 1=(0,2) 2=(0,3) 3=(1,2) 4=(1,3) 5=(2,3)
   function automatic logic [1:0] pair_p(input logic [2:0] idx);
      logic [1:0] p;
      case (idx)
         3'd0, 3'd1, 3'd2: p = 2'd0;
         3'd3, 3'd4:       p = 2'd1;
         default:          p = 2'd2;
      endcase
      return p;
   endfunction

   function automatic logic [1:0] pair_q(input logic [2:0] idx);
      logic [1:0] q;
      case (idx)
         3'd0:       q = 2'd1;
         3'd1, 3'd3: q = 2'd2;
         default:    q = 2'd3;
      endcase
      return q;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync
//   Two-flop synchronizer for one asynchronous clock, plus a delay flop
//   for rising-edge detection (rise = sync2 & ~sync3).
//   Ports:
//     sys_clk  - system clock
//     rst_n    - asynchronous active-low reset
//     async_in - monitored asynchronous clock
//     rise     - one-cycle pulse per detected rising edge of async_in
module edge_sync (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic       sync1_q, sync2_q, sync3_q;
   logic       sync1_d, sync2_d, sync3_d;
   logic [1:0] warm_q, warm_d;

   // The pipeline refills from all-zero after reset; a clock that is
   // already high would otherwise show up as a false rise. Hold off
   // detection until three cycles have passed.
   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      sync3_d = sync2_q;
      warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         warm_q  <= 2'd0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         sync3_q <= sync3_d;
         warm_q  <= warm_d;
      end
   end

   assign rise = sync2_q & ~sync3_q & (warm_q == 2'd3);

endmodule

// File: rtl/clk_pair_sched.sv
// clk_pair_sched
//   Sequentially compares the rates of pairs of asynchronous clocks. For
//   each enabled pair (P,Q) it counts sys_clk cycles spanning NEDGE rising
//   edge periods of each clock and reports equal / P<Q / P>Q / timeout.
//   Ports:
//     sys_clk, rst_n     - system clock, asynchronous active-low reset
//     mon_clk[NCLK]      - monitored asynchronous clocks
//     start, pair_mask   - sweep request and pair enables (sampled on start)
//     busy               - sweep in progress
//     res_valid          - one-cycle strobe with res_pair/res_code/res_p/res_q
//     done               - one-cycle end-of-sweep strobe
module clk_pair_sched
   import clk_sched_pkg::*;
#(
   parameter int NCLK  = 4,
   parameter int NEDGE = 4,
   parameter int AW    = 12,
   parameter int TOL   = 2,
   parameter int TMO   = 1023
) (
   input  logic            sys_clk,
   input  logic            rst_n,
   input  logic [NCLK-1:0] mon_clk,
   input  logic            start,
   input  logic [5:0]      pair_mask,
   output logic            busy,
   output logic            res_valid,
   output logic [2:0]      res_pair,
   output logic [1:0]      res_code,
   output logic [AW-1:0]   res_p,
   output logic [AW-1:0]   res_q,
   output logic            done
);

   localparam int EW = $clog2(NEDGE + 1);
   localparam int TW = $clog2(TMO + 1);
   localparam logic [AW-1:0] ACC_MAX = '1;

   logic [NCLK-1:0] rise;

   for (genvar gi = 0; gi < NCLK; gi++) begin : g_sync
      edge_sync u_sync (
         .sys_clk  (sys_clk),
         .rst_n    (rst_n),
         .async_in (mon_clk[gi]),
         .rise     (rise[gi])
      );
   end

   state_t        state_q, state_d;
   logic [5:0]    mask_q, mask_d;
   logic [2:0]    ptr_q, ptr_d;
   logic [2:0]    idx_q, idx_d;
   logic [1:0]    code_q, code_d;
   logic [TW-1:0] tmo_q, tmo_d;
   // Index 0 is the P side, index 1 the Q side.
   logic [AW-1:0] acc_q [2];
   logic [AW-1:0] acc_d [2];
   logic [EW-1:0] ecnt_q [2];
   logic [EW-1:0] ecnt_d [2];
   logic [1:0]    armed_q, armed_d;
   logic [1:0]    fin_q, fin_d;
   logic          busy_q, busy_d;
   logic          res_valid_q, res_valid_d;
   logic          done_q, done_d;
   logic [2:0]    res_pair_q, res_pair_d;
   logic [1:0]    res_code_q, res_code_d;
   logic [AW-1:0] res_p_q, res_p_d;
   logic [AW-1:0] res_q_q, res_q_d;

   logic [1:0]    side_rise;
   logic          sel_found;
   logic [2:0]    sel_idx;
   logic [AW-1:0] diff;

   // Lowest enabled pair index at or above the sweep pointer.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 3'd0;
      for (int i = NPAIR - 1; i >= 0; i--) begin
         if (mask_q[i] && (3'(i) >= ptr_q)) begin
            sel_found = 1'b1;
            sel_idx   = 3'(i);
         end
      end
   end

   always_comb begin
      side_rise[0] = rise[pair_p(idx_q)];
      side_rise[1] = rise[pair_q(idx_q)];
      diff = (acc_q[0] >= acc_q[1]) ? (acc_q[0] - acc_q[1]) : (acc_q[1] - acc_q[0]);
   end

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      ptr_d       = ptr_q;
      idx_d       = idx_q;
      code_d      = code_q;
      tmo_d       = tmo_q;
      acc_d       = acc_q;
      ecnt_d      = ecnt_q;
      armed_d     = armed_q;
      fin_d       = fin_q;
      busy_d      = busy_q;
      res_valid_d = 1'b0;
      done_d      = 1'b0;
      res_pair_d  = res_pair_q;
      res_code_d  = res_code_q;
      res_p_d     = res_p_q;
      res_q_d     = res_q_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d  = pair_mask;
               ptr_d   = 3'd0;
               busy_d  = 1'b1;
               state_d = ST_SELECT;
            end
         end

         ST_SELECT: begin
            if (sel_found) begin
               idx_d   = sel_idx;
               tmo_d   = '0;
               acc_d   = '{default: '0};
               ecnt_d  = '{default: '0};
               armed_d = 2'b00;
               fin_d   = 2'b00;
               state_d = ST_ARM;
            end else begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         ST_ARM, ST_MEASURE: begin
            // Each side runs independently: the first rise arms it, counting
            // starts the next cycle and includes the cycle of the final rise,
            // so a clean period T yields NEDGE*T.
            for (int s = 0; s < 2; s++) begin
               if (!armed_q[s]) begin
                  if (side_rise[s]) armed_d[s] = 1'b1;
               end else if (!fin_q[s]) begin
                  if (acc_q[s] != ACC_MAX) acc_d[s] = acc_q[s] + AW'(1);
                  if (side_rise[s]) begin
                     ecnt_d[s] = ecnt_q[s] + EW'(1);
                     if (ecnt_q[s] == EW'(NEDGE - 1)) fin_d[s] = 1'b1;
                  end
               end
            end
            // Completion is checked on the next-state fin flags so that a
            // finish landing on the timeout cycle still wins.
            if (fin_d == 2'b11) begin
               state_d = ST_COMPARE;
            end else if (tmo_q == TW'(TMO)) begin
               code_d  = CODE_TMO;
               state_d = ST_REPORT;
            end else begin
               tmo_d = tmo_q + TW'(1);
               if ((state_q == ST_ARM) && (armed_q == 2'b11)) state_d = ST_MEASURE;
            end
         end

         ST_COMPARE: begin
            if (diff <= AW'(TOL))         code_d = CODE_EQ;
            else if (acc_q[0] < acc_q[1]) code_d = CODE_LT;
            else                          code_d = CODE_GT;
            state_d = ST_REPORT;
         end

         ST_REPORT: begin
            res_valid_d = 1'b1;
            res_pair_d  = idx_q;
            res_code_d  = code_q;
            res_p_d     = acc_q[0];
            res_q_d     = acc_q[1];
            ptr_d       = idx_q + 3'd1;
            state_d     = ST_SELECT;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mask_q      <= '0;
         ptr_q       <= '0;
         idx_q       <= '0;
         code_q      <= '0;
         tmo_q       <= '0;
         acc_q       <= '{default: '0};
         ecnt_q      <= '{default: '0};
         armed_q     <= '0;
         fin_q       <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         done_q      <= 1'b0;
         res_pair_q  <= '0;
         res_code_q  <= '0;
         res_p_q     <= '0;
         res_q_q     <= '0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         code_q      <= code_d;
         tmo_q       <= tmo_d;
         acc_q       <= acc_d;
         ecnt_q      <= ecnt_d;
         armed_q     <= armed_d;
         fin_q       <= fin_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         done_q      <= done_d;
         res_pair_q  <= res_pair_d;
         res_code_q  <= res_code_d;
         res_p_q     <= res_p_d;
         res_q_q     <= res_q_d;
      end
   end

   assign busy      = busy_q;
   assign res_valid = res_valid_q;
   assign done      = done_q;
   assign res_pair  = res_pair_q;
   assign res_code  = res_code_q;
   assign res_p     = res_p_q;
   assign res_q     = res_q_q;

endmodule

// File: tb/tb_clk_pair_sched.sv
// tb_clk_pair_sched
//   Scoreboard bench for clk_pair_sched. Monitored clocks are generated as
//   integer multiples of sys_clk with random phase; expected results are
//   queued per sweep and compared against each res_valid strobe.
module tb_clk_pair_sched;
   import clk_sched_pkg::*;

   localparam int AW = 12;

   logic          sys_clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    mon_clk = 4'b0000;
   logic          start = 1'b0;
   logic [5:0]    pair_mask = 6'd0;
   logic          busy, res_valid, done;
   logic [2:0]    res_pair;
   logic [1:0]    res_code;
   logic [AW-1:0] res_p, res_q;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2:0] pair;
      logic [1:0] code;
      int         p_exp;
      int         q_exp;
      bit         is_tmo;
   } exp_t;

   exp_t sb[$];

   int cyc = 0;
   int res_cnt = 0;
   int done_cnt = 0;
   int last_strobe = 0;

   int half[4];
   int hcnt[4];

   always #5 sys_clk = ~sys_clk;

   clk_pair_sched #(
      .NCLK(4), .NEDGE(4), .AW(AW), .TOL(2), .TMO(1023)
   ) dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .mon_clk   (mon_clk),
      .start     (start),
      .pair_mask (pair_mask),
      .busy      (busy),
      .res_valid (res_valid),
      .res_pair  (res_pair),
      .res_code  (res_code),
      .res_p     (res_p),
      .res_q     (res_q),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit near(input logic [AW-1:0] v, input int e);
      int d;
      d = int'(v) - e;
      return (d >= -1) && (d <= 1);
   endfunction

   // Monitored clock generator: half[i]==0 holds the clock low.
   initial begin
      for (int i = 0; i < 4; i++) begin
         half[i] = 0;
         hcnt[i] = 0;
      end
      forever begin
         @(negedge sys_clk);
         for (int i = 0; i < 4; i++) begin
            if (half[i] == 0) begin
               mon_clk[i] = 1'b0;
            end else begin
               hcnt[i]++;
               if (hcnt[i] >= half[i]) begin
                  hcnt[i] = 0;
                  mon_clk[i] = ~mon_clk[i];
               end
            end
         end
      end
   end

   task automatic set_clk(input int i, input int period);
      half[i] = period / 2;
      hcnt[i] = (period == 0) ? 0 : int'($urandom_range(0, period / 2 - 1));
      if (period != 0) mon_clk[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic push(input int pair, input logic [1:0] code, input int pe, input int qe,
                       input bit tmo);
      exp_t e;
      e.pair   = 3'(pair);
      e.code   = code;
      e.p_exp  = pe;
      e.q_exp  = qe;
      e.is_tmo = tmo;
      sb.push_back(e);
   endtask

   // Result monitor / scoreboard consumer.
   initial begin
      exp_t e;
      int   gap;
      forever begin
         @(posedge sys_clk);
         #1;
         cyc++;
         if (res_valid) begin
            res_cnt++;
            gap = cyc - last_strobe;
            last_strobe = cyc;
            $display("result: pair=%0d code=%0d p=%0d q=%0d gap=%0d", res_pair, res_code,
                     res_p, res_q, gap);
            check("result_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("res_pair", 32'(res_pair), 32'(e.pair));
               check("res_code", 32'(res_code), 32'(e.code));
               check("res_p_near", 32'(near(res_p, e.p_exp)), 1);
               check("res_q_near", 32'(near(res_q, e.q_exp)), 1);
               if (e.code == CODE_EQ)
                  check("res_pq_within_tol",
                        32'((int'(res_p) - int'(res_q) <= 2) && (int'(res_q) - int'(res_p) <= 2)), 1);
               if (e.is_tmo)
                  check("tmo_gap_window", 32'((gap >= 1020) && (gap <= 1032)), 1);
            end
         end
         if (done) done_cnt++;
      end
   end

   task automatic run_sweep(input logic [5:0] mask, input bit restart_pulse,
                            output int n_busy, output int n_to_done);
      bit got_done;
      @(negedge sys_clk);
      pair_mask = mask;
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      n_busy = 0;
      n_to_done = 0;
      got_done = 1'b0;
      for (int k = 0; k < 12000; k++) begin
         if (k > 0) begin
            @(posedge sys_clk);
            #1;
         end
         if (restart_pulse && k == 20) begin
            start = 1'b1;
            pair_mask = 6'h3f;
         end else begin
            start = 1'b0;
         end
         if (busy) n_busy++;
         if (done) begin
            got_done = 1'b1;
            n_to_done = k;
            break;
         end
      end
      start = 1'b0;
      check("done_seen", 32'(got_done), 1);
      check("busy_low_at_done", 32'(busy), 0);
      @(posedge sys_clk);
      #1;
      check("done_single_pulse", 32'(done), 0);
      $display("sweep: mask=%b busy_cycles=%0d cycles_to_done=%0d", mask, n_busy, n_to_done);
   endtask

   task automatic check_outputs_zero(input string what);
      check({what, "_busy"}, 32'(busy), 0);
      check({what, "_res_valid"}, 32'(res_valid), 0);
      check({what, "_done"}, 32'(done), 0);
      check({what, "_res_pair"}, 32'(res_pair), 0);
      check({what, "_res_code"}, 32'(res_code), 0);
      check({what, "_res_p"}, 32'(res_p), 0);
      check({what, "_res_q"}, 32'(res_q), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nd;

      rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check_outputs_zero("reset");
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (5) @(posedge sys_clk);

      // Empty mask: immediate done, 1-cycle busy, no results.
      res_cnt = 0;
      run_sweep(6'b000000, 1'b0, nb, nd);
      check("empty_cycles_to_done", 32'(nd), 1);
      check("empty_busy_cycles", 32'(nb), 1);
      check("empty_res_cnt", 32'(res_cnt), 0);

      // Pair 0: P period 10, Q period 20 -> P<Q.
      set_clk(0, 10); set_clk(1, 20); set_clk(2, 0); set_clk(3, 0);
      repeat (5) @(posedge sys_clk);
      res_cnt = 0;
      push(0, CODE_LT, 40, 80, 1'b0);
      run_sweep(6'b000001, 1'b0, nb, nd);
      check("p0_res_cnt", 32'(res_cnt), 1);
      check("p0_sb_drained", 32'(sb.size()), 0);

      // Pair 1: equal periods of 16 with random phase -> equal.
      set_clk(0, 16); set_clk(1, 0); set_clk(2, 16); set_clk(3, 0);
      repeat (5) @(posedge sys_clk);
      res_cnt = 0;
      push(1, CODE_EQ, 64, 64, 1'b0);
      run_sweep(6'b000010, 1'b0, nb, nd);
      check("p1_res_cnt", 32'(res_cnt), 1);
      check("p1_sb_drained", 32'(sb.size()), 0);

      // Full mask with mon_clk3 stuck low: pairs 2,4,5 time out.
      set_clk(0, 12); set_clk(1, 12); set_clk(2, 12); set_clk(3, 0);
      repeat (5) @(posedge sys_clk);
      res_cnt = 0;
      push(0, CODE_EQ, 48, 48, 1'b0);
      push(1, CODE_EQ, 48, 48, 1'b0);
      push(2, CODE_TMO, 48, 0, 1'b1);
      push(3, CODE_EQ, 48, 48, 1'b0);
      push(4, CODE_TMO, 48, 0, 1'b1);
      push(5, CODE_TMO, 48, 0, 1'b1);
      run_sweep(6'b111111, 1'b0, nb, nd);
      check("all_res_cnt", 32'(res_cnt), 6);
      check("all_sb_drained", 32'(sb.size()), 0);

      // Start re-pulsed while busy must be ignored.
      set_clk(0, 10); set_clk(1, 10); set_clk(2, 14); set_clk(3, 14);
      repeat (5) @(posedge sys_clk);
      res_cnt = 0;
      push(0, CODE_EQ, 40, 40, 1'b0);
      push(2, CODE_LT, 40, 56, 1'b0);
      run_sweep(6'b000101, 1'b1, nb, nd);
      check("restart_res_cnt", 32'(res_cnt), 2);
      check("restart_sb_drained", 32'(sb.size()), 0);

      // Reset during MEASURE of pair 3 abandons the sweep.
      set_clk(0, 0); set_clk(1, 10); set_clk(2, 10); set_clk(3, 0);
      repeat (5) @(posedge sys_clk);
      @(negedge sys_clk);
      pair_mask = 6'b001000;
      start = 1'b1;
      @(posedge sys_clk);
      #1;
      start = 1'b0;
      repeat (30) @(posedge sys_clk);
      #1;
      check("pre_reset_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midreset");
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      rst_n = 1'b1;
      res_cnt = 0;
      done_cnt = 0;
      repeat (200) @(posedge sys_clk);
      #1;
      check("abandon_res_cnt", 32'(res_cnt), 0);
      check("abandon_done_cnt", 32'(done_cnt), 0);
      check("abandon_busy", 32'(busy), 0);

      res_cnt = 0;
      push(3, CODE_EQ, 40, 40, 1'b0);
      run_sweep(6'b001000, 1'b0, nb, nd);
      check("rerun_res_cnt", 32'(res_cnt), 1);
      check("rerun_sb_drained", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
